uart_rx: RTL

UART receiver for the serial link: recovers 8-bit frames from the asynchronous `rx_i` line using the same clock-count bit timing as the link's baud-rate generator (868 clocks per bit, 115200 baud at 100 MHz). It synchronizes the line, validates the start bit at mid-bit, samples each data bit at its centre, checks the stop bit, and presents each byte on a valid/ready output. It sits between the board RX pin and the byte consumer (command parser or FIFO), opposite the transmitter on the same link.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state (8E1 framing); default is 8N1.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
// No configuration macros are used in this file.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of 8-bit frames, delivered on a valid/ready output.
// UART_RX_PARITY_EN selects 8E1 framing with a live parity_err; otherwise 8N1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           rx_s;
    logic           par_bad;
    logic           cnt_half_hit, cnt_full_hit;
    logic           deliver, frame_set, parity_set, load;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_i),
        .q     (rx_s)
    );

    assign cnt_half_hit = (cnt == CNT_HALF);
    assign cnt_full_hit = (cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (cnt_half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (cnt_full_hit && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (cnt_full_hit) state_nxt = STOP;
`endif
            STOP:      if (cnt_full_hit) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        deliver    = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        if (state == STOP && cnt_full_hit) begin
            if (!rx_s)        frame_set  = 1'b1;
            else if (par_bad) parity_set = 1'b1;
            else              deliver    = 1'b1;
        end
    end

    // A delivery coinciding with the consumer's handshake replaces the byte without overrun.
    assign load = deliver && (!rx_valid || rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE, WAIT_IDLE: cnt <= '0;
                START:           cnt <= cnt_half_hit ? '0 : cnt + 1'b1;
                default:         cnt <= cnt_full_hit ? '0 : cnt + 1'b1;
            endcase
            if (state == START && cnt_half_hit) bit_idx <= '0;
            if (state == DATA && cnt_full_hit) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == START)
                par_bad <= 1'b0;
            else if (state == PARITY && cnt_full_hit)
                par_bad <= ^{shift, rx_s};
            parity_err <= parity_set;
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err <= frame_set;
            overrun   <= deliver && rx_valid && !rx_ready;
        end
    end

endmodule
